// File: rtl/branch_prediction_unit_pkg.sv
// Shared encodings for the branch prediction unit: PC select, 2-bit direction
// counter states and the branch/jump codes produced by decode.
package branch_prediction_unit_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_TGT  = 2'b01,
    PC_JALR = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6
  } branch_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'd0,
    JMP_JAL  = 2'd1,
    JMP_JALR = 2'd2
  } jump_e;

  function automatic logic pcsrc_taken(input logic [1:0] pcsrc);
    return pcsrc != PC_SEQ;
  endfunction

endpackage

// File: rtl/branch_prediction_unit_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down direction counter.
module sat_counter2
  import branch_prediction_unit_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_up,
  output logic [1:0] o_nxt
);

  always_comb begin
    o_nxt = i_ctr;
    if (i_up) begin
      if (i_ctr != ST) o_nxt = i_ctr + 2'd1;
    end else begin
      if (i_ctr != SNT) o_nxt = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_prediction_unit.sv
// Direct-mapped BTB with 2-bit direction counters: predicts in F, resolves,
// redirects and trains in E, and counts control instructions / mispredictions.
module branch_prediction_unit
  import branch_prediction_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = XLEN - IDX_BITS - 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pcF,
  output logic            predTakenF,
  output logic [XLEN-1:0] predTargetF,
  input  logic            validE,
  input  logic            isCtrlE,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] resolvedTargetE,
  input  logic [XLEN-1:0] pcE,
  input  logic [XLEN-1:0] pcPlus4E,
  input  logic            predTakenE,
  input  logic [XLEN-1:0] predTargetE,
  output logic            mispredictE,
  output logic [XLEN-1:0] redirectPCE,
  output logic            flushD,
  output logic            flushE,
  output logic [31:0]     ctrlCount,
  output logic [31:0]     mispredCount
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]               r_valid;
  logic [ENTRIES-1:0][TAG_BITS-1:0] r_tag;
  logic [ENTRIES-1:0][XLEN-1:0]     r_target;
  logic [ENTRIES-1:0][1:0]          r_ctr;
  logic [31:0]                      r_ctrl_cnt;
  logic [31:0]                      r_mis_cnt;

  logic [IDX_BITS-1:0]      w_idxF, w_idxE;
  logic [TAG_BITS-1:0]      w_tagF, w_tagE;
  logic                     w_hitF, w_hitE, w_takenE, w_mispredict;
  logic [ENTRIES-1:0][1:0]  w_ctr_nxt;
  logic                     w_unused;

  assign w_idxF = pcF[IDX_BITS+1:2];
  assign w_tagF = pcF[XLEN-1:IDX_BITS+2];
  assign w_idxE = pcE[IDX_BITS+1:2];
  assign w_tagE = pcE[XLEN-1:IDX_BITS+2];
  assign w_unused = ^{pcF[1:0], pcE[1:0]};

  // F reads the registered table only: E updates become visible next cycle.
  assign w_hitF      = r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);
  assign predTakenF  = w_hitF && r_ctr[w_idxF][1];
  assign predTargetF = w_hitF ? r_target[w_idxF] : '0;

  assign w_hitE   = r_valid[w_idxE] && (r_tag[w_idxE] == w_tagE);
  assign w_takenE = pcsrc_taken(PCSrcE);

  assign w_mispredict = validE && ((w_takenE != predTakenE) ||
                        (w_takenE && predTakenE && (resolvedTargetE != predTargetE)));
  assign mispredictE  = w_mispredict;
  assign flushD       = w_mispredict;
  assign flushE       = w_mispredict;
  assign redirectPCE  = w_takenE ? resolvedTargetE : pcPlus4E;
  assign ctrlCount    = r_ctrl_cnt;
  assign mispredCount = r_mis_cnt;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
    sat_counter2 u_ctr (
      .i_ctr (r_ctr[e]),
      .i_up  (w_takenE),
      .o_nxt (w_ctr_nxt[e])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= '0;
      r_tag      <= '0;
      r_target   <= '0;
      r_ctrl_cnt <= '0;
      r_mis_cnt  <= '0;
      for (int e = 0; e < ENTRIES; e++) r_ctr[e] <= WNT;
    end else if (validE) begin
      if (isCtrlE) begin
        r_ctrl_cnt <= r_ctrl_cnt + 32'd1;
        if (w_hitE) begin
          r_ctr[w_idxE] <= w_ctr_nxt[w_idxE];
          if (w_takenE) r_target[w_idxE] <= resolvedTargetE;
        end else if (w_takenE) begin
          r_valid[w_idxE]  <= 1'b1;
          r_tag[w_idxE]    <= w_tagE;
          r_target[w_idxE] <= resolvedTargetE;
          r_ctr[w_idxE]    <= WT;
        end
      end else if (w_hitE) begin
        // A non-control instruction hitting means the entry is stale or aliased.
        r_valid[w_idxE] <= 1'b0;
      end
      if (w_mispredict) r_mis_cnt <= r_mis_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Randomized + directed scoreboard bench for branch_prediction_unit against a
// behavioural BTB model built from integer counters and per-index records.
module tb_branch_prediction_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        predTakenF;
  logic [31:0] predTargetF;
  logic        validE, isCtrlE;
  logic [1:0]  PCSrcE;
  logic [31:0] resolvedTargetE, pcE, pcPlus4E;
  logic        predTakenE;
  logic [31:0] predTargetE;
  logic        mispredictE;
  logic [31:0] redirectPCE;
  logic        flushD, flushE;
  logic [31:0] ctrlCount, mispredCount;

  branch_prediction_unit dut (
    .clk(clk), .rst(rst), .pcF(pcF), .predTakenF(predTakenF), .predTargetF(predTargetF),
    .validE(validE), .isCtrlE(isCtrlE), .PCSrcE(PCSrcE), .resolvedTargetE(resolvedTargetE),
    .pcE(pcE), .pcPlus4E(pcPlus4E), .predTakenE(predTakenE), .predTargetE(predTargetE),
    .mispredictE(mispredictE), .redirectPCE(redirectPCE), .flushD(flushD), .flushE(flushE),
    .ctrlCount(ctrlCount), .mispredCount(mispredCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pt;
    logic [31:0] ptg;
    logic        mis;
    logic [31:0] rd;
    logic [31:0] cc;
    logic [31:0] mc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Behavioural table: one record per index, direction strength as an integer 0..3.
  bit          m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_cnt [16];
  int unsigned m_cc, m_mc;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
    end
    m_cc = 0; m_mc = 0;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_v[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[pc[5:2]] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[pc[5:2]] : 32'h0;
  endfunction

  task automatic step(input bit rstv, input bit vE, input bit isC, input logic [1:0] src,
                      input logic [31:0] rt, input logic [31:0] pe, input bit pte,
                      input logic [31:0] ptg, input logic [31:0] pf);
    exp_t e;
    bit act, hit;
    int idx;
    @(posedge clk);
    #1;
    rst = rstv; validE = vE; isCtrlE = isC; PCSrcE = src; resolvedTargetE = rt;
    pcE = pe; pcPlus4E = pe + 32'd4; predTakenE = pte; predTargetE = ptg; pcF = pf;
    if (!rstv) model_reset();
    act   = (src != 2'b00);
    e.pt  = m_pred(pf);
    e.ptg = m_ptgt(pf);
    e.mis = rstv && vE && ((act != pte) || (act && pte && rt != ptg));
    e.rd  = act ? rt : pe + 32'd4;
    e.cc  = m_cc;
    e.mc  = m_mc;
    q.push_back(e);
    if (rstv && vE) begin
      idx = int'(pe[5:2]);
      hit = m_hit(pe);
      if (isC) begin
        m_cc++;
        if (hit) begin
          if (act) begin
            m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
            m_tgt[idx] = rt;
          end else begin
            m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
          end
        end else if (act) begin
          m_v[idx] = 1; m_tag[idx] = pe[31:6]; m_tgt[idx] = rt; m_cnt[idx] = 2;
        end
      end else if (hit) begin
        m_v[idx] = 0;
      end
      if (e.mis) m_mc++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a fresh response every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("predTakenF",   {31'd0, predTakenF}, {31'd0, e.pt});
      chk("predTargetF",  predTargetF, e.ptg);
      chk("mispredictE",  {31'd0, mispredictE}, {31'd0, e.mis});
      chk("flushD",       {31'd0, flushD}, {31'd0, e.mis});
      chk("flushE",       {31'd0, flushE}, {31'd0, e.mis});
      chk("redirectPCE",  redirectPCE, e.rd);
      chk("ctrlCount",    ctrlCount, e.cc);
      chk("mispredCount", mispredCount, e.mc);
    end
  end

  localparam logic [31:0] POOL [8] = '{32'h40, 32'h80, 32'h100, 32'h44, 32'hC0,
                                      32'h0C, 32'h1040, 32'h200};

  initial begin
    logic [31:0] pe, pf, rt, ptg;
    logic [1:0]  src;
    bit          isC, pte;
    int          waited;
    model_reset();
    rst = 1'b0; validE = 0; isCtrlE = 0; PCSrcE = 2'b00; resolvedTargetE = '0;
    pcE = '0; pcPlus4E = 32'd4; predTakenE = 0; predTargetE = '0; pcF = '0;

    // reset state
    step(0, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h40);
    step(1, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h40);
    // cold taken branch, same-cycle read of the index sees the old entry
    step(1, 1, 1, 2'b01, 32'h80, 32'h40, 0, 0, 32'h40);
    step(1, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h40);
    // saturate, then two not-taken resolutions
    repeat (3) step(1, 1, 1, 2'b01, 32'h80, 32'h40, 1, 32'h80, 32'h40);
    step(1, 1, 1, 2'b00, 32'h0, 32'h40, 1, 32'h80, 32'h40);
    step(1, 1, 1, 2'b00, 32'h0, 32'h40, 1, 32'h80, 32'h40);
    step(1, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h40);
    // JALR target change
    step(1, 1, 1, 2'b10, 32'h200, 32'h100, 0, 0, 32'h100);
    step(1, 1, 1, 2'b10, 32'h200, 32'h100, 1, 32'h200, 32'h100);
    step(1, 1, 1, 2'b10, 32'h300, 32'h100, 1, 32'h200, 32'h100);
    step(1, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h100);
    // aliasing eviction by a non-control instruction
    step(1, 1, 1, 2'b01, 32'h80, 32'h40, 0, 0, 32'h40);
    step(1, 1, 0, 2'b00, 32'h0, 32'h40, 1, 32'h80, 32'h80);
    step(1, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h40);
    step(1, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h80);
    // bubble with a taken select must not train or count
    step(1, 0, 1, 2'b01, 32'h900, 32'h40, 0, 0, 32'h40);
    step(1, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h40);
    // train index 3, then reset mid-run
    step(1, 1, 1, 2'b01, 32'h500, 32'h0C, 0, 0, 32'h0C);
    step(1, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0C);
    step(0, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0C);
    step(1, 0, 0, 2'b00, 0, 32'h0, 0, 0, 32'h0C);

    // random traffic over a small aliasing PC pool
    for (int n = 0; n < 600; n++) begin
      pe  = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFC) : POOL[$urandom_range(0, 7)];
      pf  = ($urandom_range(0, 3) == 0) ? pe : POOL[$urandom_range(0, 7)];
      isC = ($urandom_range(0, 4) != 0);
      src = isC ? 2'($urandom_range(0, 2)) : 2'b00;
      rt  = ($urandom_range(0, 1) == 1) ? POOL[$urandom_range(0, 7)] : ($urandom() & 32'hFFFC);
      if ($urandom_range(0, 3) != 0) begin
        pte = m_pred(pe); ptg = m_ptgt(pe);
      end else begin
        pte = 1'($urandom()); ptg = $urandom();
      end
      step(1, ($urandom_range(0, 5) != 0), isC, src, rt, pe, pte, ptg, pf);
    end

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_prediction_unit.md
Name: branch_prediction_unit

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters for the pipelined RISC-V core.
- In F: predicts whether the fetched PC is a taken control transfer, and its target.
- In E: compares the branch controller's resolved PCSrcE against the prediction carried down the pipe, raises the redirect and flush, and trains the table.
- Keeps two performance counters.

Parameters:
- XLEN, 32, datapath/PC width.
- IDX_BITS, 4, BTB index width; ENTRIES = 2^IDX_BITS; index = pc[IDX_BITS+1:2].
- TAG_BITS, XLEN-IDX_BITS-2, tag = pc[XLEN-1:IDX_BITS+2].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pcF  input  XLEN  PC of the instruction in fetch.
- predTakenF  output  1  predicted taken (combinational).
- predTargetF  output  XLEN  predicted target (combinational).
- validE  input  1  E-stage holds a real (non-bubble) instruction.
- isCtrlE  input  1  E instruction is a branch/JAL/JALR (branchE != 0 or jumpE != 0).
- PCSrcE  input  2  resolved select from the branch controller: 00 fall-through, 01 branch/JAL target, 10 JALR target.
- resolvedTargetE  input  XLEN  actual target selected by the datapath for PCSrcE != 00.
- pcE  input  XLEN  PC of the E instruction.
- pcPlus4E  input  XLEN  pcE+4.
- predTakenE  input  1  predTakenF carried to E by the pipeline registers.
- predTargetE  input  XLEN  predTargetF carried to E.
- mispredictE  output  1  redirect required (combinational).
- redirectPCE  output  XLEN  correct next PC when mispredictE=1.
- flushD  output  1  equals mispredictE.
- flushE  output  1  equals mispredictE.
- ctrlCount  output  32  resolved control instructions (registered).
- mispredCount  output  32  mispredictions (registered).

Behaviour:
- Entry fields: valid, tag[TAG_BITS], target[XLEN], ctr[2].
- Reset (rst=0, async): all valid=0, all ctr=2'b01, both counters=0.
  - Combinational outputs follow from the cleared state: predTakenF=0, predTargetF=0.
  - Reset mid-operation discards all training immediately.
- F lookup:
  - hitF = valid[idxF] && tag[idxF]==tagF.
  - predTakenF = hitF && ctr[idxF][1].
  - predTargetF = hitF ? target[idxF] : 0.
  - No write-to-read bypass: a same-cycle E update to the same index becomes visible to F from the next cycle.
- E resolution: actualTaken = (PCSrcE != 00).
- Misprediction:
  - mispredictE = validE && ( actualTaken != predTakenE || (actualTaken && predTakenE && resolvedTargetE != predTargetE) ).
  - redirectPCE = actualTaken ? resolvedTargetE : pcPlus4E.
  - The datapath gives redirectPCE priority over predTargetF and pcF+4.
- Update on rising clk, only when validE=1. idxE and tagE are taken from pcE.
  - isCtrlE, hit, taken: ctr saturating increment (max 11), target <= resolvedTargetE.
  - isCtrlE, hit, not taken: ctr saturating decrement (min 00), target unchanged.
  - isCtrlE, miss, taken: allocate/overwrite with valid=1, tag=tagE, target=resolvedTargetE, ctr=2'b10.
  - isCtrlE, miss, not taken: no change.
  - !isCtrlE with hit: valid <= 0 (evicts a stale/aliased entry).
  - validE=0: no update, counters hold, mispredictE=0.
- Counters:
  - ctrlCount += 1 when validE && isCtrlE.
  - mispredCount += 1 when mispredictE.
  - Both wrap modulo 2^32.
- JAL/JALR use the same path: an always-taken entry saturates at 11. A JALR target change is a target mispredict.
- A stalled E stage is expected to present validE=0 for repeated cycles, or the same instruction once. The unit counts once per cycle that validE=1.

Decomposition:
- Shared package holds:
  - PCSrc encodings (PC_SEQ=00, PC_TGT=01, PC_JALR=10);
  - counter encodings (SNT=00, WNT=01, WT=10, ST=11);
  - the branch/jump encodings already used by the branch controller.
- One natural sub-module: sat_counter2, a 2-bit saturating up/down next-state function used per entry.
- BTB storage stays as register arrays inside this block (async reset required).

Test Plan:
- Reset: assert rst=0 mid-run after training index 3 → next cycle pcF with index 3 gives predTakenF=0, predTargetF=0, ctrlCount=0, mispredCount=0.
- Cold taken branch: pcE=0x40, PCSrcE=01, resolvedTargetE=0x80, predTakenE=0 → mispredictE=1, redirectPCE=0x80, flushD=flushE=1. Next cycle pcF=0x40 gives predTakenF=1, predTargetF=0x80, and mispredCount=1.
- Saturation: resolve 0x40 taken 3 more times → ctr=11 (no overflow). Then 2 not-taken resolutions with predTakenE=1 → first mispredicts with redirectPCE=0x44, ctr=10. Second: ctr=01 and predTakenF=0.
- JALR target change: entry 0x100→0x200 at ctr=11; resolve with PCSrcE=10, resolvedTargetE=0x300, predTakenE=1, predTargetE=0x200 → mispredictE=1, redirectPCE=0x300. Table target becomes 0x300.
- Aliasing/eviction: entry for 0x40 valid; pcE=0x40, isCtrlE=0, predTakenE=1 → mispredictE=1, redirectPCE=0x44, entry invalidated. With IDX_BITS=4, pcF=0x80 (same index, different tag) → predTakenF=0.
- Bubble/same-cycle: validE=0 with PCSrcE=01 → no update, mispredictE=0, counters unchanged. Update to index k while pcF reads index k → predTakenF reflects the old value that cycle and the new value the next cycle.
